// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for the core's fetch port, loaded by a host
// over a valid/ready word stream. The core is held in reset until a complete
// program has been loaded.
// Optional feature macro: LOAD_CHECKSUM_EN. When it is defined, the host sends one
// extra word after the program. That word must equal the XOR of all program words.
//
// Handshake: a host word is transferred on every rising clk edge where
// ld_valid && ld_ready. ld_ready depends only on the FSM state, never on ld_valid.
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_start,
  input  logic [DEPTH_LOG2:0]   ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  ld_err,
  output logic                  core_rst_n,
  input  logic                  rom_enable,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_data,
  output logic [2:0]            dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MAX_LEN = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);

`ifdef LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_CSUM = 3'd2, S_RUN = 3'd3, S_ERR = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd3, S_ERR = 3'd4
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
  logic                    core_rst_n_q, core_rst_n_d;
  logic                    mem_we;
  logic                    len_ok;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
`endif

  assign len_ok = (ld_len != '0) && (ld_len <= MAX_LEN);

  // Next-state logic: load sequencing, start decision, core reset release
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (ld_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          cnt_d    = cnt_q - CNT_ONE;
`ifdef LOAD_CHECKSUM_EN
          csum_d   = csum_q ^ ld_data;
          if (cnt_q == CNT_ONE) state_d = S_CSUM;
`else
          if (cnt_q == CNT_ONE) state_d = S_RUN;
`endif
        end
      end
`ifdef LOAD_CHECKSUM_EN
      S_CSUM: begin
        if (ld_valid) state_d = (ld_data == csum_q) ? S_RUN : S_ERR;
      end
`endif
      default: begin
        // IDLE, RUN and ERR all take the same start decision
        if (ld_start) begin
          state_d  = len_ok ? S_LOAD : S_ERR;
          wr_ptr_d = '0;
          cnt_d    = ld_len;
`ifdef LOAD_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
    endcase
    // Released only once RUN has been held for a full cycle; dropped as soon as RUN is left
    core_rst_n_d = (state_q == S_RUN) && (state_d == S_RUN);
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  // Running XOR of program words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  // Program memory write port (array contents are not reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= ld_data;
  end

`ifdef LOAD_CHECKSUM_EN
  assign ld_ready = (state_q == S_LOAD) || (state_q == S_CSUM);
`else
  assign ld_ready = (state_q == S_LOAD);
`endif
  assign ld_done     = (state_q == S_RUN);
  assign ld_err      = (state_q == S_ERR);
  assign core_rst_n  = core_rst_n_q;
  assign dbg_state_o = state_q;

  // Byte-address bits below word granularity play no part in the fetch
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^rom_addr[1:0];

  // Combinational fetch; anything outside RUN or beyond the array returns 0 (NOP)
  always_comb begin
    rom_data = '0;
    if (rom_enable && (state_q == S_RUN) &&
        (rom_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0)) begin
      rom_data = mem[rom_addr[DEPTH_LOG2+1:2]];
    end
  end

endmodule
